// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and FSM encoding for the BCD-to-binary converter.
package bcd_to_bin_pkg;
  localparam int DIGITS       = 5;
  localparam int WIDTH        = 16;
  localparam int SHIFT_CYCLES = 17;
  localparam int MAG_BITS     = 17;
  localparam int CNT_BITS     = 5;

  localparam logic [MAG_BITS-1:0] MAX_POS = 17'd32767;
  localparam logic [MAG_BITS-1:0] MAX_NEG = 17'd32768;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > 4'd9;
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD field: values >= 8 lose 3.
module bcd_digit_adjust
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  assign adjusted = (digit >= 4'd8) ? (digit - 4'd3) : digit;
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential signed BCD to two's-complement converter, fixed 19-cycle latency.
module bcd_to_bin #(
  parameter int DIGITS = bcd_to_bin_pkg::DIGITS,
  parameter int WIDTH  = bcd_to_bin_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       D_one,
  input  logic [3:0]       D_two,
  input  logic [3:0]       D_three,
  input  logic [3:0]       D_four,
  input  logic [3:0]       D_five,
  input  logic             sign,
  output logic [WIDTH-1:0] h_number,
  output logic             busy,
  output logic             done,
  output logic             error
);
  import bcd_to_bin_pkg::*;

  localparam int BCD_BITS = DIGITS * 4;

  // state is left as a named internal signal so checkers can bind to it
  state_t                state;
  logic [BCD_BITS-1:0]   bcd;
  logic [MAG_BITS-1:0]   mag;
  logic [CNT_BITS-1:0]   cnt;
  logic                  sign_q;
  logic                  bad_q;

  logic [BCD_BITS-1:0]          bcd_in;
  logic                         bad_in;
  logic [BCD_BITS+MAG_BITS-1:0] shifted;
  logic [BCD_BITS-1:0]          bcd_adj;
  logic [MAG_BITS-1:0]          neg_mag;
  logic                         range_err;

  assign bcd_in = {D_five, D_four, D_three, D_two, D_one};

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_in = bad_in | digit_invalid(bcd_in[4*i +: 4]);
    end
  end

  assign shifted = {bcd, mag} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted[MAG_BITS + 4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  assign neg_mag   = ~mag + 1'b1;
  // negative side allows one extra count (-32768)
  assign range_err = sign_q ? (mag > MAX_POS) : (mag > MAX_NEG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bcd      <= '0;
      mag      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      bad_q    <= 1'b0;
      h_number <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd    <= bcd_in;
            sign_q <= sign;
            bad_q  <= bad_in;
            mag    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_adj;
          mag <= shifted[MAG_BITS-1:0];
          if (cnt == CNT_BITS'(SHIFT_CYCLES - 1)) begin
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          if (bad_q || range_err) begin
            h_number <= '0;
            error    <= 1'b1;
          end else begin
            h_number <= sign_q ? mag[WIDTH-1:0] : neg_mag[WIDTH-1:0];
            error    <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed vector table, multi-cycle corner sequences, loopback.
module tb_bcd_to_bin;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  D_one, D_two, D_three, D_four, D_five;
  logic        sign;
  logic [15:0] h_number;
  logic        busy, done, error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [19:0] bcd;
    logic        sgn;
    logic [15:0] h;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  bcd_to_bin dut (
    .clk(clk), .reset(reset), .start(start),
    .D_one(D_one), .D_two(D_two), .D_three(D_three), .D_four(D_four), .D_five(D_five),
    .sign(sign), .h_number(h_number), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_digits(input logic [19:0] b, input logic s);
    {D_five, D_four, D_three, D_two, D_one} = b;
    sign = s;
  endtask

  // Start one conversion, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_conv(input logic [19:0] b, input logic s,
                          output logic [15:0] h, output logic e, output int lat);
    @(negedge clk);
    drive_digits(b, s);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drive_digits(20'($urandom), 1'($urandom));
    lat = -1;
    h = '0;
    e = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        h = h_number;
        e = error;
      end
    end
  endtask

  function automatic void bin_to_bcd(input logic [15:0] v, output logic [19:0] b, output logic s);
    int m;
    s = ~v[15];
    m = v[15] ? (65536 - int'(v)) : int'(v);
    b = {4'(m / 10000 % 10), 4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction

  initial begin
    logic [15:0] h;
    logic        e;
    int          lat;
    int          n_done;
    int          t_first, t_second;
    logic [19:0] lb_bcd;
    logic        lb_sgn;
    logic [15:0] lb_val;

    vecs[0]  = '{20'h12345, 1'b1, 16'h3039, 1'b0};
    vecs[1]  = '{20'h32768, 1'b0, 16'h8000, 1'b0};
    vecs[2]  = '{20'h32768, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{20'h12A45, 1'b1, 16'h0000, 1'b1};
    vecs[4]  = '{20'h99999, 1'b1, 16'h0000, 1'b1};
    vecs[5]  = '{20'h00000, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{20'h00001, 1'b0, 16'hFFFF, 1'b0};
    vecs[7]  = '{20'h32767, 1'b1, 16'h7FFF, 1'b0};
    vecs[8]  = '{20'h32767, 1'b0, 16'h8001, 1'b0};
    vecs[9]  = '{20'h65535, 1'b1, 16'h0000, 1'b1};
    vecs[10] = '{20'h00000, 1'b1, 16'h0000, 1'b0};
    vecs[11] = '{20'h00255, 1'b0, 16'hFF01, 1'b0};
    vecs[12] = '{20'h40000, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{20'h09999, 1'b1, 16'h270F, 1'b0};
    vecs[14] = '{20'h01000, 1'b1, 16'h03E8, 1'b0};
    vecs[15] = '{20'h0000F, 1'b1, 16'h0000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    drive_digits(20'h0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_h", 32'(h_number), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(error), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 16; i++) begin
      run_conv(vecs[i].bcd, vecs[i].sgn, h, e, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd18);
      check($sformatf("vec%0d_h", i), 32'(h), 32'(vecs[i].h));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
    end

    // done is a single-cycle pulse and h_number holds afterwards
    run_conv(20'h12345, 1'b1, h, e, lat);
    @(posedge clk);
    #1;
    check("done_width", 32'(done), 32'h0);
    check("hold_h", 32'(h_number), 32'h3039);
    check("idle_busy", 32'(busy), 32'h0);

    // start re-asserted during SHIFT edge 5 is ignored
    @(negedge clk);
    drive_digits(20'h00042, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(busy), 32'h1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive_digits(20'h00077, 1'b1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        check("busy_start_h", 32'(h_number), 32'h002A);
      end
    end
    check("busy_start_done_count", 32'(n_done), 32'd1);

    // reset at SHIFT edge 8 aborts with no done
    @(negedge clk);
    drive_digits(20'h12345, 1'b1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_h", 32'(h_number), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_done_count", 32'(n_done), 32'd0);

    // start held high: back-to-back conversions every 19 cycles
    @(negedge clk);
    drive_digits(20'h01000, 1'b0);
    start = 1'b1;
    n_done = 0;
    t_first = -1;
    t_second = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
        check("b2b_h", 32'(h_number), 32'hFC18);
      end
    end
    check("b2b_count", 32'(n_done), 32'd3);
    check("b2b_interval", 32'(t_second - t_first), 32'd19);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(posedge clk);

    // loopback through a behavioural binary-to-BCD model
    for (int i = 0; i < 206; i++) begin
      case (i)
        0: lb_val = 16'h0000;
        1: lb_val = 16'h0001;
        2: lb_val = 16'h7FFF;
        3: lb_val = 16'h8000;
        4: lb_val = 16'h8001;
        5: lb_val = 16'hFFFF;
        default: lb_val = 16'($urandom_range(0, 65535));
      endcase
      bin_to_bcd(lb_val, lb_bcd, lb_sgn);
      run_conv(lb_bcd, lb_sgn, h, e, lat);
      check($sformatf("loop_%04h_h", lb_val), 32'(h), 32'(lb_val));
      check($sformatf("loop_%04h_err", lb_val), 32'(e), 32'h0);
      check($sformatf("loop_%04h_lat", lb_val), 32'(lat), 32'd18);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 5: number of BCD input digits.
REQ-002 SHALL have parameter WIDTH, default 16: two's-complement result width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request a conversion; sampled only in IDLE.
REQ-006 SHALL have ports D_one..D_five, input, 4 each: BCD digits; D_one is units, D_five is ten-thousands.
REQ-007 SHALL have port sign, input, 1: 1 = non-negative, 0 = negative (same polarity as the binary-to-BCD converter's sign output).
REQ-008 SHALL have port h_number, output, 16: registered two's-complement result.
REQ-009 SHALL have port busy, output, 1: high from the cycle after start is accepted until the cycle after the FINISH state completes.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when h_number and error are valid.
REQ-011 SHALL have port error, output, 1: registered; valid with done; set for an invalid digit or an out-of-range value.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and FINISH.
REQ-013 In IDLE with start=1, SHALL do the following at that edge (edge 0): latch the digits and sign into a 20-bit BCD shift register, clear the 17-bit magnitude register, clear the counter, and enter SHIFT.
REQ-014 On each SHIFT edge, SHALL shift {bcd, mag} right by one bit, then subtract 3 from every 4-bit BCD field that is now >= 8 (reverse double dabble).
REQ-015 SHIFT SHALL last exactly 17 edges (edges 1..17) with the counter running 0..16, then enter FINISH.
REQ-016 On the FINISH edge (edge 18), SHALL write h_number and error, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-017 Fixed latency: done SHALL be high in the cycle following edge 18, for every input including error cases.
REQ-018 Invalid digit: any latched digit > 9 SHALL give error=1 and h_number=16'h0000.
REQ-019 Range: a positive magnitude > 32767 or a negative magnitude > 32768 SHALL give error=1 and h_number=16'h0000.
REQ-020 A negative result SHALL be h_number = (~mag + 1) truncated to 16 bits; negative zero SHALL give 16'h0000 with error=0.
REQ-021 h_number and error SHALL hold their values until the next FINISH or reset.
REQ-022 Start while busy (SHIFT or FINISH) SHALL be ignored, with no queuing; input digit changes after edge 0 SHALL NOT affect the result.
REQ-023 Start held high continuously SHALL be accepted again on the first IDLE cycle after done, giving back-to-back conversions every 19 cycles.

Reset
REQ-024 reset=1 SHALL, at the clock edge, set the state to IDLE and clear h_number, done, error, busy, the counter and the shift registers.
REQ-025 reset SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL never produce a done pulse.

Structure
REQ-026 A shared package/header SHALL hold DIGITS, WIDTH, SHIFT_CYCLES=17, the FSM state encodings, and the limits MAX_POS=32767 and MAX_NEG=32768.
REQ-027 The per-digit ">= 8 then subtract 3" correction SHALL be a sub-module, bcd_digit_adjust (4-bit in, 4-bit out), instantiated DIGITS times.

Verification
REQ-028 Digits 1,2,3,4,5 with sign=1 and start SHALL produce h_number=16'h3039, error=0, and done high in the cycle after edge 18.
REQ-029 Digits 3,2,7,6,8 with sign=0 SHALL produce h_number=16'h8000 and error=0; the same digits with sign=1 SHALL produce error=1 and h_number=16'h0000.
REQ-030 D_three=4'hA SHALL produce error=1 and h_number=16'h0000 at the normal latency; digits 9,9,9,9,9 SHALL produce error=1.
REQ-031 Digits 0,0,0,0,0 with sign=0 SHALL produce h_number=16'h0000 and error=0; digits 0,0,0,0,1 with sign=0 SHALL produce 16'hFFFF.
REQ-032 Start pulsed again at SHIFT edge 5 SHALL be ignored, with exactly one done; reset at SHIFT edge 8 SHALL give busy=0 and h_number=0 the next cycle and no done pulse.
REQ-033 A loopback check SHALL convert every 16-bit value through the existing binary-to-BCD converter into bcd_to_bin and get the original value back with error=0.
